uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver. Successor to the fixed 8-bit/9600-baud receiver:
//  configurable data width, parity mode and stop bits, 3-sample majority vote,
//  framing/parity error flags, and a valid/ready output with overrun detection.
//  Sits between the board rx pin and any consumer (display decoders, FIFO, CPU).
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency (Hz)
//  BAUD       9600        line rate; BIT_CNT = CLK_HZ/BAUD (integer divide), HALF_CNT = BIT_CNT/2
//  DATA_BITS  8           data bits per frame, legal 5..9, LSB first on the line
//  PARITY     0           0 = none, 1 = odd, 2 = even
//  STOP_BITS  1           1 or 2
// PORTS
//  clk         in   1          system clock, rising edge
//  n_rst       in   1          asynchronous active-low reset
//  rx          in   1          serial line, idle high, asynchronous to clk
//  rx_data     out  DATA_BITS  received word, valid while rx_valid=1
//  rx_valid    out  1          word available; held until consumed
//  rx_ready    in   1          consumer accepts the word when rx_valid & rx_ready
//  parity_err  out  1          parity mismatch on the held word (0 when PARITY=0)
//  frame_err   out  1          some stop bit sampled 0 on the held word
//  overrun     out  1          at least one frame lost while the word was held
//  busy        out  1          FSM is not in IDLE
//  break_det   out  1          one-cycle break pulse (tied 0 without macro)
// BEHAVIOUR
//  - Reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0,
//    break_det=0, sync flops=1, FSM=IDLE, counters=0. Reset mid-frame aborts the frame.
//  - rx passes through a 2-flop synchroniser; all logic uses the synced value rs.
//  - Sampling: bit value = majority of rs at counts HALF_CNT-1, HALF_CNT, HALF_CNT+1
//    of each bit period; baud counter restarts at 0 on the start edge, wraps at BIT_CNT-1.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
//    IDLE  : rs 1->0 -> START, clear counters, busy=1.
//    START : at mid-sample, vote 1 -> IDLE (glitch, nothing reported); vote 0 -> DATA.
//    DATA  : shift in DATA_BITS votes LSB first; -> PARITY if PARITY!=0, else STOP.
//    PARITY: compare vote with odd/even of data; mismatch sets pending parity_err.
//    STOP  : STOP_BITS votes; any 0 sets pending frame_err. At last stop mid-sample commit
//            and -> IDLE immediately (back-to-back frames with no idle gap are received).
//  - Commit: rx_data/parity_err/frame_err updated 1 clk after last stop-bit mid-sample; rx_valid=1.
//  - Handshake: word consumed on clk where rx_valid & rx_ready; rx_valid drops next clk
//    unless a commit occurs the same clk (new word loads, rx_valid stays 1, overrun=0).
//  - Commit while rx_valid=1 and not consumed: new frame dropped, held word and its flags
//    unchanged, overrun=1 (sticky until that word is consumed).
//  - Flags are per-word: cleared with rx_valid on consume, reloaded on each commit.
// CONFIGURATION
//  Macro UART_RX_BREAK_DETECT_EN:
//   defined  : start, all data, parity and first stop votes all 0 -> break_det pulses 1 clk,
//              no commit, FSM -> BRK_WAIT until rs=1, then IDLE.
//   undefined: such a frame commits as data 0 with frame_err=1; BRK_WAIT unused; break_det=0.
// STRUCTURE
//  - Shared include uart_defs.vh: parity encodings (PAR_NONE/ODD/EVEN), FSM state localparams.
//  - One sub-module uart_baud_tick: counter with restart, outputs mid-window strobes
//    (HALF_CNT-1, HALF_CNT, HALF_CNT+1) and end-of-bit strobe; width $clog2(BIT_CNT).
//  - Top holds synchroniser, FSM, shift register, vote logic, output register/handshake.
// TESTING  (bench uses CLK_HZ=160, BAUD=10 -> BIT_CNT=16; rx_ready=1 unless noted)
//  1 8N1, send 0x55 -> rx_valid 1 clk after stop mid-sample, rx_data=0x55, all flags 0.
//  2 8E1, send 0xA3 with parity bit 1 (wrong) -> rx_data=0xA3, parity_err=1, frame_err=0.
//  3 8N1, send 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1; next frame 0x41 clean.
//  4 rx low for 4 clks then high -> busy pulses, returns to IDLE, rx_valid stays 0.
//  5 rx_ready=0, send 0x41 then 0x42 -> rx_data=0x41, overrun=1; raise rx_ready ->
//    rx_valid and overrun drop next clk.
//  6 rx low 12 bit times -> macro: break_det 1-clk pulse, no rx_valid, idle after rx high;
//    no macro: rx_valid with 0x00, frame_err=1.
//  Also: n_rst pulse mid-DATA -> all outputs at reset values, next frame received cleanly.

Source files
------------

// File: rtl/uart_rx_param_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param_pkg
// Description : Shared definitions for the parametrised UART receiver:
//               parity mode encodings, receiver FSM state type and the
//               3-sample majority helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_param_pkg;

    // Parity mode encodings used by the PARITY parameter
    localparam int c_par_none = 0;
    localparam int c_par_odd  = 1;
    localparam int c_par_even = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_param_baud_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param_baud_tick
// Description : Bit-period counter for the UART receiver. Restarts at 0,
//               counts while enabled and wraps at BIT_CNT-1. Emits strobes
//               at the three mid-bit sample points and at end of bit.
// Ports       : clk, n_rst       - clock, async active-low reset
//               restart          - clear the counter (start edge)
//               enable           - count this cycle
//               mid_lo/mid_c/mid_hi - count == HALF_CNT-1 / HALF_CNT / HALF_CNT+1
//               bit_end          - count == BIT_CNT-1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param_baud_tick #(
    parameter int BIT_CNT = 16
) (
    input  logic clk,
    input  logic n_rst,
    input  logic restart,
    input  logic enable,
    output logic mid_lo,
    output logic mid_c,
    output logic mid_hi,
    output logic bit_end
);

    localparam int c_half  = BIT_CNT / 2;
    localparam int c_cnt_w = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;

    localparam logic [c_cnt_w-1:0] c_mid_lo = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_mid_c  = c_cnt_w'(c_half);
    localparam logic [c_cnt_w-1:0] c_mid_hi = c_cnt_w'(c_half + 1);
    localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(BIT_CNT - 1);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (restart) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_one;
        end
    end

    assign mid_lo  = enable && (r_cnt == c_mid_lo);
    assign mid_c   = enable && (r_cnt == c_mid_c);
    assign mid_hi  = enable && (r_cnt == c_mid_hi);
    assign bit_end = enable && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised UART receiver with 2-flop synchroniser,
//               3-sample majority vote, parity/framing error flags and a
//               valid/ready output register with sticky overrun.
//               Optional break detection is enabled by defining the macro
//               UART_RX_BREAK_DETECT_EN; otherwise break_det is tied 0 and an
//               all-zero line commits as data 0 with frame_err set.
// Ports       : clk, n_rst   - clock, async active-low reset
//               rx           - serial line (idle high, asynchronous)
//               rx_data      - received word, valid while rx_valid
//               rx_valid     - word held until consumed
//               rx_ready     - consumer accepts on rx_valid & rx_ready
//               parity_err   - parity mismatch on held word
//               frame_err    - a stop bit sampled 0 on held word
//               overrun      - a frame was lost while the word was held
//               busy         - FSM not idle
//               break_det    - one-cycle break pulse
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic                 break_det
);

    localparam int         c_bit_cnt   = CLK_HZ / BAUD;
    localparam logic [3:0] c_last_bit  = 4'(DATA_BITS - 1);
    localparam logic       c_last_stop = (STOP_BITS == 2);

    rx_state_t            r_state;
    logic                 r_sync1;
    logic                 r_rs;
    logic                 r_rs_d;
    logic                 r_s0;
    logic                 r_s1;
    logic [3:0]           r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;
    logic                 r_commit;

    logic w_start_edge;
    logic w_mid_lo;
    logic w_mid_c;
    logic w_vote_stb;
    logic w_bit_end;
    logic w_vote;
    logic w_par_exp;
    logic w_unused_bit_end;

    // ------------------------------------------------------------------
    // Synchroniser; r_rs_d gives the previous synced value for edge detect
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b1;
            r_rs    <= 1'b1;
            r_rs_d  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rs    <= r_sync1;
            r_rs_d  <= r_rs;
        end
    end

    // A start needs a genuine 1->0 transition, so a line left low after a
    // bad stop bit does not re-trigger a frame.
    assign w_start_edge = (r_state == ST_IDLE) && !r_rs && r_rs_d;

    uart_rx_param_baud_tick #(
        .BIT_CNT (c_bit_cnt)
    ) u_baud (
        .clk     (clk),
        .n_rst   (n_rst),
        .restart (w_start_edge),
        .enable  (busy),
        .mid_lo  (w_mid_lo),
        .mid_c   (w_mid_c),
        .mid_hi  (w_vote_stb),
        .bit_end (w_bit_end)
    );

    // Bit decisions are taken at mid-window, so end-of-bit is not needed here
    assign w_unused_bit_end = w_bit_end;

    // ------------------------------------------------------------------
    // Mid-bit samples; the third sample is the live value at vote time
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (w_mid_lo) r_s0 <= r_rs;
            if (w_mid_c)  r_s1 <= r_rs;
        end
    end

    assign w_vote = maj3(r_s0, r_s1, r_rs);

    always_comb begin
        w_par_exp = 1'b0;
        if (PARITY == c_par_odd)       w_par_exp = ~(^r_shift);
        else if (PARITY == c_par_even) w_par_exp = ^r_shift;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic r_saw_one;
    logic r_break;
    logic w_break;

    // Any 1 vote since the start edge rules out a break
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_saw_one <= 1'b0;
        end else if (w_start_edge) begin
            r_saw_one <= 1'b0;
        end else if (w_vote_stb && w_vote) begin
            r_saw_one <= 1'b1;
        end
    end

    assign w_break   = !r_stop_idx && !w_vote && !r_saw_one;
    assign break_det = r_break;
`else
    assign break_det = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_commit   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_break    <= 1'b0;
`endif
        end else begin
            r_commit <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            r_break  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_state    <= ST_START;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_par_err  <= 1'b0;
                        r_frm_err  <= 1'b0;
                    end
                end
                ST_START: begin
                    // A start bit that votes 1 was a glitch
                    if (w_vote_stb) r_state <= w_vote ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (w_vote_stb) begin
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == c_last_bit) begin
                            r_state <= (PARITY != c_par_none) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_vote_stb) begin
                        r_par_err <= (w_vote != w_par_exp);
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_vote_stb) begin
                        if (!w_vote) r_frm_err <= 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (w_break) begin
                            r_break <= 1'b1;
                            r_state <= ST_BRK_WAIT;
                        end else
`endif
                        if (r_stop_idx == c_last_stop) begin
                            // Straight back to IDLE so a following start bit
                            // with no idle gap is still caught
                            r_commit <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                ST_BRK_WAIT: begin
                    if (r_rs) r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (r_state != ST_IDLE);

    // ------------------------------------------------------------------
    // Output register and handshake. A commit while an unconsumed word is
    // held drops the new frame and flags overrun against the held word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (r_commit) begin
            if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
            end else begin
                rx_data    <= r_shift;
                rx_valid   <= 1'b1;
                parity_err <= r_par_err;
                frame_err  <= r_frm_err;
                overrun    <= 1'b0;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Self-checking bench for uart_rx_param. Two instances share
//               the clock and reset: an 8N1 receiver and an 8E1 receiver,
//               each on its own serial line. Frames are built bit by bit
//               from the line format and received words are compared with
//               values derived from the frame contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

    localparam int CLK_HZ = 160;
    localparam int BAUD   = 10;
    localparam int BT     = CLK_HZ / BAUD;

    logic       clk     = 1'b0;
    logic       n_rst   = 1'b0;
    logic       rx_n    = 1'b1;
    logic       rx_e    = 1'b1;
    logic       ready_n = 1'b1;
    logic       ready_e = 1'b1;
    logic [7:0] data_n, data_e;
    logic       valid_n, perr_n, ferr_n, ovr_n, busy_n, brk_n;
    logic       valid_e, perr_e, ferr_e, ovr_e, busy_e, brk_e;

    int cyc        = 0;
    int n_checks   = 0;
    int n_pass     = 0;
    int busy_cyc_n = 0;
    int brk_cnt_n  = 0;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
        int         cyc;
    } word_t;

    word_t q_n[$];
    word_t q_e[$];

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_dut_n (
        .clk(clk), .n_rst(n_rst), .rx(rx_n), .rx_data(data_n), .rx_valid(valid_n),
        .rx_ready(ready_n), .parity_err(perr_n), .frame_err(ferr_n),
        .overrun(ovr_n), .busy(busy_n), .break_det(brk_n)
    );

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u_dut_e (
        .clk(clk), .n_rst(n_rst), .rx(rx_e), .rx_data(data_e), .rx_valid(valid_e),
        .rx_ready(ready_e), .parity_err(perr_e), .frame_err(ferr_e),
        .overrun(ovr_e), .busy(busy_e), .break_det(brk_e)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted word with its flags and the cycle it was seen
    always @(negedge clk) begin
        if (valid_n && ready_n) q_n.push_back('{data_n, perr_n, ferr_n, ovr_n, cyc});
        if (valid_e && ready_e) q_e.push_back('{data_e, perr_e, ferr_e, ovr_e, cyc});
        if (busy_n) busy_cyc_n <= busy_cyc_n + 1;
        if (brk_n)  brk_cnt_n  <= brk_cnt_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx_n = v;
        else            rx_e = v;
    endtask

    // Even parity on the 8E1 line: an error when the ones count of data plus
    // the transmitted parity bit is odd. The 8N1 line never reports parity.
    function automatic logic exp_perr(input int which, input logic [7:0] d, input logic pb);
        if (which == 0) return 1'b0;
        return ((($countones(d) + int'(pb)) % 2) == 1);
    endfunction

    // Start bit, 8 data bits LSB first, optional parity bit, one stop bit
    task automatic send_frame(input int which, input logic [7:0] d, input logic pb,
                              input logic stop, output int start_cyc);
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (which == 1) b.push_back(pb);
        b.push_back(stop);
        start_cyc = cyc;
        foreach (b[i]) begin
            set_rx(which, b[i]);
            tick(BT);
        end
        set_rx(which, 1'b1);
    endtask

    // Exactly one word expected, appearing in the second half of the stop bit
    task automatic expect_word(input string tag, input int which, input logic [7:0] d,
                               input logic pe, input logic fe, input int sc);
        word_t w;
        int    s;
        int    lo;
        s  = (which == 0) ? 9 : 10;
        lo = sc + BT * s + BT / 2;
        if (which == 0) begin
            check({tag, "_count"}, q_n.size(), 1);
            if (q_n.size() == 0) return;
            w = q_n.pop_front();
            q_n.delete();
        end else begin
            check({tag, "_count"}, q_e.size(), 1);
            if (q_e.size() == 0) return;
            w = q_e.pop_front();
            q_e.delete();
        end
        check({tag, "_data"}, w.data, d);
        check({tag, "_flags"}, {w.perr, w.ferr, w.ovr}, {pe, fe, 1'b0});
        check({tag, "_lat"}, (w.cyc >= lo && w.cyc <= lo + BT / 2 - 1), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         sc;
        int         which;
        int         gap;
        int         b0;
        logic [7:0] d;
        logic       pb;
        logic       sb;

        // Reset state
        tick(3);
        check("rst_n_outs", {valid_n, perr_n, ferr_n, ovr_n, busy_n, brk_n}, 0);
        check("rst_n_data", data_n, 0);
        check("rst_e_outs", {valid_e, perr_e, ferr_e, ovr_e, busy_e, brk_e, data_e}, 0);
        n_rst = 1'b1;
        tick(8);

        // Clean 8N1 frame
        send_frame(0, 8'h55, 1'b0, 1'b1, sc);
        tick(4);
        expect_word("t1", 0, 8'h55, 1'b0, 1'b0, sc);

        // 8E1 with wrong parity: 0xA3 has four ones, so even parity is 0
        send_frame(1, 8'hA3, 1'b1, 1'b1, sc);
        tick(4);
        expect_word("t2", 1, 8'hA3, 1'b1, 1'b0, sc);

        // Stop bit 0 then a clean frame
        send_frame(0, 8'h3C, 1'b0, 1'b0, sc);
        expect_word("t3a", 0, 8'h3C, 1'b0, 1'b1, sc);
        tick(2);
        send_frame(0, 8'h41, 1'b0, 1'b1, sc);
        expect_word("t3b", 0, 8'h41, 1'b0, 1'b0, sc);
        tick(8);

        // Short low glitch
        b0 = busy_cyc_n;
        set_rx(0, 1'b0);
        tick(4);
        set_rx(0, 1'b1);
        tick(3 * BT);
        check("t4_busy_seen", (busy_cyc_n > b0), 1);
        check("t4_idle", {busy_n, valid_n}, 0);
        check("t4_no_word", q_n.size(), 0);

        // Overrun: two back-to-back frames with consumer stalled
        ready_n = 1'b0;
        send_frame(0, 8'h41, 1'b0, 1'b1, sc);
        send_frame(0, 8'h42, 1'b0, 1'b1, sc);
        tick(10);
        check("t5_valid", valid_n, 1);
        check("t5_data", data_n, 8'h41);
        check("t5_flags", {ovr_n, ferr_n, perr_n}, 3'b100);
        ready_n = 1'b1;
        tick(1);
        check("t5_drop", {valid_n, ovr_n}, 0);
        check("t5_count", q_n.size(), 1);
        if (q_n.size() > 0) check("t5_acc_data", q_n[0].data, 8'h41);
        q_n.delete();
        tick(8);

        // Line held low for 12 bit times
        b0 = brk_cnt_n;
        set_rx(0, 1'b0);
        sc = cyc;
        tick(12 * BT);
        set_rx(0, 1'b1);
        tick(3 * BT);
`ifdef UART_RX_BREAK_DETECT_EN
        check("t6_break_pulses", brk_cnt_n - b0, 1);
        check("t6_no_word", q_n.size(), 0);
        check("t6_idle", {busy_n, valid_n}, 0);
`else
        check("t6_break_pulses", brk_cnt_n - b0, 0);
        expect_word("t6", 0, 8'h00, 1'b0, 1'b1, sc);
        check("t6_idle", busy_n, 0);
`endif

        // Reset in the middle of the data bits
        set_rx(0, 1'b0);
        tick(BT);
        set_rx(0, 1'b1);
        tick(BT);
        set_rx(0, 1'b0);
        tick(BT / 2);
        n_rst = 1'b0;
        set_rx(0, 1'b1);
        tick(2);
        check("rst_mid_outs", {valid_n, perr_n, ferr_n, ovr_n, busy_n, brk_n}, 0);
        check("rst_mid_data", data_n, 0);
        n_rst = 1'b1;
        tick(2 * BT);
        check("rst_mid_no_word", q_n.size(), 0);
        send_frame(0, 8'hC7, 1'b0, 1'b1, sc);
        expect_word("rst_after", 0, 8'hC7, 1'b0, 1'b0, sc);

        // Randomised frames on both lines
        for (int i = 0; i < 24; i++) begin
            which = int'($urandom_range(0, 1));
            d     = 8'($urandom);
            pb    = 1'($urandom);
            sb    = ($urandom_range(0, 5) != 0);
            gap   = int'($urandom_range(0, 24));
            // Keep clear of the all-zero break pattern and make sure a
            // low stop bit is followed by a rising edge before the next start
            if (!sb && d == 8'h00) d = 8'h01;
            if (!sb && gap < 2) gap = 2;
            send_frame(which, d, pb, sb, sc);
            expect_word("rnd", which, d, exp_perr(which, d, pb), !sb, sc);
            if (gap > 0) tick(gap);
        end

        tick(2 * BT);
        check("end_idle", {busy_n, busy_e, valid_n, valid_e}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
